// File: rtl/uart_adder_requester.sv
// uart_adder_requester
//   Host-side initiator for the UART adder service. A request sends two 8N1
//   bytes, LSB first, on o_Tx_Serial:
//     byte A = {3'b000, carry_in, a}
//     byte B = {4'b0000, b}
//   The block then waits for a one-byte response on i_Rx_Serial. The result
//   is presented on the parallel port: rsp[3:0] is the sum, rsp[4] is the
//   carry, and rsp[7:5] must be zero.
//
// Ports
//   i_Clock       system clock
//   i_Reset_n     asynchronous active-low reset
//   i_Start       request strobe, sampled only while idle
//   i_A, i_B      4-bit operands (latched when the request is accepted)
//   i_Carry_In    carry in (latched with the operands)
//   i_Rx_Serial   response line from the adder (synchronised internally)
//   o_Tx_Serial   request line to the adder (idles high)
//   o_Busy        high while a transaction is in flight
//   o_Done        one-cycle completion pulse
//   o_Error       framing error, timeout or malformed response; valid with o_Done
//   o_Sum         result sum, held until the next successful completion
//   o_Carry_Out   result carry, same validity as o_Sum
module uart_adder_requester #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int TIMEOUT_CLKS = 20840
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic       i_Carry_In,
  input  logic       i_Rx_Serial,
  output logic       o_Tx_Serial,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Error,
  output logic [3:0] o_Sum,
  output logic       o_Carry_Out
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT_RSP,
    ST_RECV,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [3:0]       sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= ST_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tx_shift_q <= '1;
      b_q        <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      tmo_q      <= '0;
      rx_shift_q <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= i_Rx_Serial;
      rx_sync_q  <= rx_meta_q;
      tx_shift_q <= tx_shift_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      tmo_q      <= tmo_d;
      rx_shift_q <= rx_shift_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    tmo_d      = tmo_q;
    rx_shift_d = rx_shift_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          // The frame is loaded as {stop, data, start}. Bit 0 drives the
          // line, so the start bit appears on the cycle after acceptance.
          state_d    = ST_SEND_A;
          tx_shift_d = {1'b1, 3'b000, i_Carry_In, i_A, 1'b0};
          b_d        = i_B;
          cnt_d      = '0;
          bit_idx_d  = '0;
        end
      end

      ST_SEND_A, ST_SEND_B: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            bit_idx_d = '0;
            if (state_q == ST_SEND_A) begin
              // Byte B follows the stop bit of byte A with no idle gap.
              state_d    = ST_SEND_B;
              tx_shift_d = {1'b1, 4'b0000, b_q, 1'b0};
            end else begin
              state_d    = ST_WAIT_RSP;
              tx_shift_d = '1;
              tmo_d      = '0;
            end
          end else begin
            bit_idx_d  = bit_idx_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_RSP: begin
        // The timeout keeps running while a start bit is being verified. It
        // saturates, so a long run of glitches cannot wrap it.
        if (tmo_q != TMO_W'(TIMEOUT_CLKS)) tmo_d = tmo_q + TMO_W'(1);
        // cnt_q == 0 means the block is hunting for a falling edge. A
        // non-zero value means it is counting towards the mid-start recheck.
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            cnt_d = CNT_W'(1);
          end else if (tmo_q >= TMO_W'(TIMEOUT_CLKS - 1)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end else if (cnt_q == CNT_W'(HALF_BIT)) begin
          if (!rx_sync_q) begin
            // Start bit confirmed. From here every full bit period lands on
            // a bit centre.
            state_d   = ST_RECV;
            cnt_d     = CNT_W'(1);
            bit_idx_d = '0;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECV: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT)) begin
          cnt_d = CNT_W'(1);
          if (bit_idx_q == 4'd8) begin
            // This is the stop-bit sample. On error the previous result is
            // kept on the port.
            state_d = ST_DONE;
            if (!rx_sync_q || (rx_shift_q[7:5] != 3'b000)) begin
              err_d = 1'b1;
            end else begin
              err_d   = 1'b0;
              sum_d   = rx_shift_q[3:0];
              carry_d = rx_shift_q[4];
            end
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Tx_Serial = tx_shift_q[0];
  assign o_Busy      = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) ||
                       (state_q == ST_WAIT_RSP) || (state_q == ST_RECV);
  assign o_Done      = (state_q == ST_DONE);
  assign o_Error     = err_q;
  assign o_Sum       = sum_q;
  assign o_Carry_Out = carry_q;

endmodule

// File: tb/tb_uart_adder_requester.sv
// Directed bench for uart_adder_requester with CLKS_PER_BIT=8 and
// TIMEOUT_CLKS=400.
module tb_uart_adder_requester;

  localparam int CPB = 8;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       cin;
  logic       rx;
  logic       tx, busy, done, err, carry;
  logic [3:0] sum;

  always #5 clk = ~clk;

  uart_adder_requester #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start), .i_A(a_in), .i_B(b_in),
    .i_Carry_In(cin), .i_Rx_Serial(rx), .o_Tx_Serial(tx), .o_Busy(busy),
    .o_Done(done), .o_Error(err), .o_Sum(sum), .o_Carry_Out(carry)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] rsp;
    logic       stop;
    logic       poke;
    logic       inject;
    logic [7:0] exp_txa;
    logic [7:0] exp_txb;
    logic       exp_err;
    logic [3:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic       last_err;
  logic [3:0] last_sum;
  logic       last_carry;

  // Latch what the DUT presents on every completion pulse.
  always @(negedge clk) begin
    if (done) begin
      done_cnt   <= done_cnt + 1;
      last_err   <= err;
      last_sum   <= sum;
      last_carry <= carry;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue a request and check both frames bit by bit (160 cycles). The task
  // returns at the negedge of the last cycle of byte B's stop bit.
  task automatic run_request(input logic [3:0] a, input logic [3:0] b, input logic c,
                             input logic poke, input logic inject,
                             input logic [7:0] exp_a, input logic [7:0] exp_b,
                             input string tag);
    logic [7:0] byte_v, cap_a, cap_b;
    logic       exp_bit;
    int         bad_a, bad_b, frame, bitn;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;   // operands must already be latched
    check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
    bad_a = 0; bad_b = 0; cap_a = '0; cap_b = '0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      frame  = i / 80;
      bitn   = (i % 80) / CPB;
      byte_v = (frame == 0) ? exp_a : exp_b;
      if (bitn == 0)      exp_bit = 1'b0;
      else if (bitn == 9) exp_bit = 1'b1;
      else                exp_bit = byte_v[bitn-1];
      if (tx !== exp_bit) begin
        if (frame == 0) bad_a++;
        else            bad_b++;
      end
      if ((i % CPB) == CPB/2 && bitn >= 1 && bitn <= 8) begin
        if (frame == 0) cap_a[bitn-1] = tx;
        else            cap_b[bitn-1] = tx;
      end
      if (poke && i == 20) start = 1'b1;
      if (poke && i == 21) start = 1'b0;
      if (inject && i >= 8 && i < 40) rx = ((i % 4) < 2) ? 1'b0 : 1'b1;
      if (inject && i == 40) rx = 1'b1;
    end
    check({tag, " tx byte A"}, {24'd0, cap_a}, {24'd0, exp_a});
    check({tag, " tx byte B"}, {24'd0, cap_b}, {24'd0, exp_b});
    check({tag, " tx bad cycles A"}, bad_a, 0);
    check({tag, " tx bad cycles B"}, bad_b, 0);
  endtask

  task automatic send_rsp(input logic [7:0] d, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rx = (k == 0) ? 1'b0 : ((k == 9) ? stop : d[k-1]);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_done(input int prev, input string tag);
    for (int k = 0; k < 100 && done_cnt == prev; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({tag, " done pulses"}, done_cnt, prev + 1);
  endtask

  initial begin
    int   prev, lat, quiet;
    logic t_err, t_carry;
    logic [3:0] t_sum;

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset error", {31'd0, err}, 32'd0);
    check("reset sum", {28'd0, sum}, 32'd0);
    check("reset carry", {31'd0, carry}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{a:4'hA, b:4'h7, cin:1'b1, rsp:8'h12, stop:1'b1, poke:1'b0, inject:1'b0,
                exp_txa:8'h1A, exp_txb:8'h07, exp_err:1'b0, exp_sum:4'h2, exp_carry:1'b1};
    vecs[1] = '{a:4'h3, b:4'h4, cin:1'b0, rsp:8'h07, stop:1'b1, poke:1'b1, inject:1'b0,
                exp_txa:8'h03, exp_txb:8'h04, exp_err:1'b0, exp_sum:4'h7, exp_carry:1'b0};
    vecs[2] = '{a:4'h5, b:4'h6, cin:1'b0, rsp:8'h12, stop:1'b0, poke:1'b0, inject:1'b0,
                exp_txa:8'h05, exp_txb:8'h06, exp_err:1'b1, exp_sum:4'h7, exp_carry:1'b0};
    vecs[3] = '{a:4'hF, b:4'hF, cin:1'b1, rsp:8'hE5, stop:1'b1, poke:1'b0, inject:1'b0,
                exp_txa:8'h1F, exp_txb:8'h0F, exp_err:1'b1, exp_sum:4'h7, exp_carry:1'b0};
    vecs[4] = '{a:4'h0, b:4'h0, cin:1'b0, rsp:8'h00, stop:1'b1, poke:1'b0, inject:1'b0,
                exp_txa:8'h00, exp_txb:8'h00, exp_err:1'b0, exp_sum:4'h0, exp_carry:1'b0};
    vecs[5] = '{a:4'h8, b:4'h9, cin:1'b1, rsp:8'h12, stop:1'b1, poke:1'b0, inject:1'b1,
                exp_txa:8'h18, exp_txb:8'h09, exp_err:1'b0, exp_sum:4'h2, exp_carry:1'b1};

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag  = $sformatf("vec%0d", v);
      prev = done_cnt;
      run_request(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].poke, vecs[v].inject,
                  vecs[v].exp_txa, vecs[v].exp_txb, tag);
      @(negedge clk);
      send_rsp(vecs[v].rsp, vecs[v].stop);
      wait_done(prev, tag);
      check({tag, " error"}, {31'd0, last_err}, {31'd0, vecs[v].exp_err});
      check({tag, " sum"}, {28'd0, last_sum}, {28'd0, vecs[v].exp_sum});
      check({tag, " carry"}, {31'd0, last_carry}, {31'd0, vecs[v].exp_carry});
      $display("txn %s: a=%h b=%h cin=%b rsp=%h stop=%b -> err=%b sum=%h carry=%b",
               tag, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].rsp, vecs[v].stop,
               last_err, last_sum, last_carry);
      if (vecs[v].poke) begin
        quiet = 1;
        prev  = done_cnt;
        repeat (150) begin
          @(negedge clk);
          if (tx !== 1'b1 || busy !== 1'b0) quiet = 0;
        end
        check({tag, " ignored start stays idle"}, quiet, 1);
        check({tag, " ignored start no done"}, done_cnt, prev);
      end
    end

    // No response: the error pulse arrives exactly TMO cycles after B's stop bit.
    prev = done_cnt;
    run_request(4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, "tmo");
    lat = -1; t_err = 1'b0; t_sum = '0; t_carry = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1; t_err = err; t_sum = sum; t_carry = carry;
        break;
      end
    end
    check("tmo latency", lat, TMO);
    check("tmo error", {31'd0, t_err}, 32'd1);
    check("tmo sum held", {28'd0, t_sum}, 32'h2);
    check("tmo carry held", {31'd0, t_carry}, 32'd1);
    $display("txn tmo: a=1 b=2 cin=0 no response -> latency=%0d err=%b sum=%h carry=%b",
             lat, t_err, t_sum, t_carry);

    // Issued on the first idle cycle after the timeout pulse (back-to-back),
    // followed by a start-bit glitch and then a valid response.
    prev = done_cnt + 1;
    run_request(4'h7, 4'h8, 1'b0, 1'b0, 1'b0, 8'h07, 8'h08, "glitch");
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch no done", done_cnt, prev);
    send_rsp(8'h0F, 1'b1);
    wait_done(prev, "glitch");
    check("glitch error", {31'd0, last_err}, 32'd0);
    check("glitch sum", {28'd0, last_sum}, 32'hF);
    check("glitch carry", {31'd0, last_carry}, 32'd0);
    $display("txn glitch: a=7 b=8 cin=0 rsp=0f -> err=%b sum=%h carry=%b",
             last_err, last_sum, last_carry);

    // Reset in the middle of byte A, while the line is driving a 0 data bit.
    @(negedge clk);
    a_in = 4'h0; b_in = 4'h0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    check("pre-reset tx low", {31'd0, tx}, 32'd0);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    prev  = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid-reset tx", {31'd0, tx}, 32'd1);
    check("mid-reset busy", {31'd0, busy}, 32'd0);
    check("mid-reset done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    check("post-reset line idle", quiet, 1);
    check("reset no done", done_cnt, prev);
    $display("txn reset: abandoned mid byte A -> tx=%b busy=%b", tx, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
